// File: rtl/use_wor_bus.sv
// Wired-OR resolution of two gated drivers (A&B, C|D) with registered copy and conflict flag.
// Define WOR_STATS_EN to add the saturating hit_cnt statistics counter.
module use_wor_bus #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [1:0]       drv_en,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] f_q,
    output logic             conflict_q
`ifdef WOR_STATS_EN
    ,
    output logic [CNT_W-1:0] hit_cnt
`endif
);

    logic [WIDTH-1:0] w_d0;
    logic [WIDTH-1:0] w_d1;
    logic [WIDTH-1:0] w_f;
    logic             w_conflict;

    // A disabled driver pulls nothing, so the net resolves to 0 rather than high-Z.
    assign w_d0       = drv_en[0] ? (A & B) : '0;
    assign w_d1       = drv_en[1] ? (C | D) : '0;
    assign w_f        = w_d0 | w_d1;
    assign w_conflict = drv_en[0] & drv_en[1] & (|(w_d0 ^ w_d1));

    assign f = w_f;

    logic [WIDTH-1:0] r_f_q;
    logic             r_conflict_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_f_q        <= '0;
            r_conflict_q <= 1'b0;
        end else begin
            r_f_q        <= w_f;
            r_conflict_q <= w_conflict;
        end
    end

    assign f_q        = r_f_q;
    assign conflict_q = r_conflict_q;

`ifdef WOR_STATS_EN
    logic [CNT_W-1:0] r_hit_cnt;

    // Holds at all-ones instead of wrapping so long activity never reads as low activity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_cnt <= '0;
        end else if ((w_f != '0) && (r_hit_cnt != {CNT_W{1'b1}})) begin
            r_hit_cnt <= r_hit_cnt + 1'b1;
        end
    end

    assign hit_cnt = r_hit_cnt;
`endif

endmodule

// File: tb/tb_use_wor_bus.sv
// Directed testbench for use_wor_bus: per-cycle model comparison plus hand-computed checks.
// Define WOR_STATS_EN to also exercise the saturating hit counter (CNT_W = 2).
module tb_use_wor_bus;

    localparam int WIDTH = 1;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] A, B, C, D;
    logic [1:0]       drv_en;
    logic [WIDTH-1:0] f, f_q;
    logic             conflict_q;
`ifdef WOR_STATS_EN
    logic [CNT_W-1:0] hit_cnt;
`endif

    int checks = 0;
    int errors = 0;
    bit check_en = 0;

    use_wor_bus #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .A          (A),
        .B          (B),
        .C          (C),
        .D          (D),
        .drv_en     (drv_en),
        .f          (f),
        .f_q        (f_q),
        .conflict_q (conflict_q)
`ifdef WOR_STATS_EN
        ,
        .hit_cnt    (hit_cnt)
`endif
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the net is high when any enabled driver sources a 1;
    // a conflict is two enabled drivers that disagree.
    function automatic logic model_f(input logic a, b, c, d, input logic [1:0] en);
        int sources;
        sources = 0;
        if (en[0] && a && b) sources++;
        if (en[1] && (c || d)) sources++;
        return (sources > 0);
    endfunction

    function automatic logic model_conflict(input logic a, b, c, d, input logic [1:0] en);
        logic v0, v1;
        v0 = a && b;
        v1 = c || d;
        return en[0] && en[1] && (v0 != v1);
    endfunction

    logic m_fq;
    logic m_conf;
    int   m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fq   = 1'b0;
            m_conf = 1'b0;
            m_cnt  = 0;
        end else begin
            if (model_f(A, B, C, D, drv_en)) m_cnt = (m_cnt + 1 > 3) ? 3 : m_cnt + 1;
            m_fq   = model_f(A, B, C, D, drv_en);
            m_conf = model_conflict(A, B, C, D, drv_en);
        end
    end

    // Compare process: checks every cycle on the falling edge.
    always @(negedge clk) begin
        if (check_en) begin
            check("cyc_f", f, model_f(A, B, C, D, drv_en));
            check("cyc_f_q", f_q, m_fq);
            check("cyc_conflict_q", conflict_q, m_conf);
`ifdef WOR_STATS_EN
            check("cyc_hit_cnt", hit_cnt, m_cnt);
`endif
        end
    end

    // Driver: change inputs shortly after a rising edge.
    task automatic drive(input logic a, b, c, d, input logic [1:0] en);
        @(posedge clk);
        #2;
        A = a; B = b; C = c; D = d; drv_en = en;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

`ifdef WOR_STATS_EN
    logic [CNT_W-1:0] exp_q[$];
`endif

    initial begin
        rst = 1'b1;
        A = 0; B = 0; C = 0; D = 0; drv_en = 2'b11;
        #3;
        check("reset_f_q", f_q, 0);
        check("reset_conflict_q", conflict_q, 0);
`ifdef WOR_STATS_EN
        check("reset_hit_cnt", hit_cnt, 0);
`endif
        #9 rst = 1'b0;
        check_en = 1;

        // d0=0, d1=1: net high and drivers disagree
        drive(1, 0, 1, 0, 2'b11);
        #1 check("t1_f_comb", f, 1);
        after_edge();
        check("t1_f_q", f_q, 1);
        check("t1_conflict_q", conflict_q, 1);

        drive(0, 0, 0, 1, 2'b11);
        #1 check("t2a_f", f, 1);
        after_edge();
        check("t2a_conflict_q", conflict_q, 1);
        drive(1, 1, 1, 0, 2'b11);
        #1 check("t2b_f", f, 1);
        after_edge();
        check("t2b_conflict_q", conflict_q, 0);

        drive(1, 0, 0, 1, 2'b11);
        #1 check("t3a_f", f, 1);
        drive(0, 0, 0, 0, 2'b11);
        #1 check("t3b_f", f, 0);
        check("t3b_f_q_holds", f_q, 1);
        after_edge();
        check("t3b_f_q", f_q, 0);
        check("t3b_conflict_q", conflict_q, 0);

        drive(1, 0, 1, 1, 2'b01);
        #1 check("t4a_f", f, 0);
        after_edge();
        check("t4a_conflict_q", conflict_q, 0);
        drive(1, 1, 1, 1, 2'b00);
        #1 check("t4b_f", f, 0);
        after_edge();
        check("t4b_f_q", f_q, 0);

        drive(0, 1, 0, 0, 2'b11);
        drive(1, 1, 0, 0, 2'b10);
        #1 check("t5_only_d1_off", f, 0);

        // Hold f=1, then reset between edges
        drive(1, 1, 1, 1, 2'b11);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async_f_q", f_q, 0);
        check("rst_async_conflict_q", conflict_q, 0);
        check("rst_f_unaffected", f, 1);
`ifdef WOR_STATS_EN
        check("rst_async_hit_cnt", hit_cnt, 0);
`endif
        @(posedge clk);
        #1 check("rst_held_f_q", f_q, 0);
        #2 rst = 1'b0;
        after_edge();
        check("post_rst_f_q", f_q, 1);
`ifdef WOR_STATS_EN
        exp_q = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        check("sat_hit_0", hit_cnt, exp_q.pop_front());
        while (exp_q.size() > 0) begin
            after_edge();
            check("sat_hit", hit_cnt, exp_q.pop_front());
        end
`endif
        repeat (2) @(posedge clk);
        #6;
        check_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
